// File: rtl/div_32_pkg.sv
// Shared definitions for the div_32 multicycle signed divider.
// Holds the controller state encoding and the default datapath width.
package div_32_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_32_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor with a WIDTH+1-bit carry-lookahead subtractor, keep or restore.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  localparam int N  = WIDTH + 1;
  localparam int NG = (N + 3) / 4;

  logic [N-1:0]  a_w;
  logic [N-1:0]  bn_w;
  logic [N-1:0]  p_w;
  logic [N-2:0]  g_w;
  logic [N-1:0]  c_w;
  logic [N-1:0]  diff_w;
  logic [NG-1:0] gc_w;
  logic [NG-2:0] grp_g_w;
  logic [NG-2:0] grp_p_w;

  // a - b computed as a + ~b + 1; the +1 enters as the carry into group 0
  assign a_w    = {rem_i, bit_i};
  assign bn_w   = ~{1'b0, divisor_i};
  assign p_w    = a_w ^ bn_w;
  assign g_w    = a_w[N-2:0] & bn_w[N-2:0];
  assign gc_w[0] = 1'b1;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    localparam int B = 4 * gi;
    if (gi > 0) begin : g_gc
      assign gc_w[gi] = grp_g_w[gi-1] | (grp_p_w[gi-1] & gc_w[gi-1]);
    end
    if (gi < NG - 1) begin : g_gp
      assign grp_g_w[gi] = g_w[B+3] | (p_w[B+3] & g_w[B+2])
                         | (p_w[B+3] & p_w[B+2] & g_w[B+1])
                         | (p_w[B+3] & p_w[B+2] & p_w[B+1] & g_w[B]);
      assign grp_p_w[gi] = &p_w[B+3:B];
    end
    assign c_w[B] = gc_w[gi];
    if (B + 1 < N) begin : g_c1
      assign c_w[B+1] = g_w[B] | (p_w[B] & gc_w[gi]);
    end
    if (B + 2 < N) begin : g_c2
      assign c_w[B+2] = g_w[B+1] | (p_w[B+1] & g_w[B])
                      | (p_w[B+1] & p_w[B] & gc_w[gi]);
    end
    if (B + 3 < N) begin : g_c3
      assign c_w[B+3] = g_w[B+2] | (p_w[B+2] & g_w[B+1])
                      | (p_w[B+2] & p_w[B+1] & g_w[B])
                      | (p_w[B+2] & p_w[B+1] & p_w[B] & gc_w[gi]);
    end
  end

  assign diff_w = p_w ^ c_w;
  assign q_o    = ~diff_w[N-1];
  // The kept remainder is always below the divisor, so WIDTH bits suffice.
  assign rem_o  = q_o ? diff_w[WIDTH-1:0] : a_w[WIDTH-1:0];

endmodule

// File: rtl/div_32.sv
// Multicycle signed divider: magnitudes are divided one restoring step per
// cycle, then signs are fixed up (quotient toward zero, remainder follows A).
module div_32
  import div_32_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  // As an unsigned WIDTH-bit value, |-2^(W-1)| = 2^(W-1) is exact.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? neg(x) : x;
  endfunction

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] dvd_q, dsr_q, rem_q;
  logic [WIDTH-1:0] result_q, remainder_q;
  logic             qneg_q, rneg_q, ovf_q;
  logic             exc_q, rdy_q, busy_q;
  logic [WIDTH-1:0] rem_d;
  logic             qbit_d;
  logic             ovf_d;

  assign ovf_d = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .divisor_i (dsr_q),
    .rem_o     (rem_d),
    .q_o       (qbit_d)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      result_q    <= '0;
      remainder_q <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      ovf_q       <= 1'b0;
      exc_q       <= 1'b0;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rdy_q  <= 1'b0;
      busy_q <= ctrl_DIV || (state_q != IDLE);
      // A new start always wins, aborting whatever was in flight.
      if (ctrl_DIV) begin
        dvd_q  <= mag(data_operandA);
        dsr_q  <= mag(data_operandB);
        rem_q  <= '0;
        cnt_q  <= '0;
        qneg_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        rneg_q <= data_operandA[WIDTH-1];
        ovf_q  <= ovf_d;
        if (data_operandB == '0) begin
          result_q    <= '0;
          remainder_q <= data_operandA;
          exc_q       <= 1'b1;
          state_q     <= DONE;
        end else begin
          state_q <= RUN;
        end
      end else begin
        case (state_q)
          RUN: begin
            rem_q <= rem_d;
            dvd_q <= {dvd_q[WIDTH-2:0], qbit_d};
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) state_q <= FIX;
          end
          FIX: begin
            result_q    <= qneg_q ? neg(dvd_q) : dvd_q;
            remainder_q <= rneg_q ? neg(rem_q) : rem_q;
            exc_q       <= ovf_q;
            state_q     <= DONE;
          end
          DONE: begin
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign data_result    = result_q;
  assign data_remainder = remainder_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_div_32.sv
// Directed-vector bench for div_32: latency, busy window, signs, divide by
// zero, overflow, abort by restart and abort by reset.
module tb_div_32;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic [31:0] data_remainder;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  div_32 dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives a start pulse sampled at the next rising edge (edge T).
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    ctrl_DIV      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
  endtask

  // Watches 40 cycles after edge T; k is the number of edges past T.
  task automatic expect_done(input string tag, input int exp_lat, input logic [31:0] q,
                             input logic [31:0] r, input logic e);
    int          lat = -1;
    int          pulses = 0;
    logic [31:0] q_s = '0;
    logic [31:0] r_s = '0;
    logic        e_s = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      if (k == 1) check({tag, "_busy_first"}, 32'(busy), 32'd1);
      if (data_resultRDY) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          q_s = data_result;
          r_s = data_remainder;
          e_s = data_exception;
          check({tag, "_busy_at_rdy"}, 32'(busy), 32'd1);
        end
      end
      if (lat > 0 && k == lat + 1) check({tag, "_busy_after"}, 32'(busy), 32'd0);
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rdy_pulses"}, 32'(pulses), 32'd1);
    check({tag, "_quotient"}, q_s, q);
    check({tag, "_remainder"}, r_s, r);
    check({tag, "_exception"}, 32'(e_s), 32'(e));
    $display("%s: q=0x%08h r=0x%08h exc=%0d lat=%0d", tag, q_s, r_s, e_s, lat);
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input int lat, input logic [31:0] q, input logic [31:0] r, input logic e);
    issue(a, b);
    expect_done(tag, lat, q, r, e);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("reset_result", data_result, 32'd0);
    check("reset_remainder", data_remainder, 32'd0);
    check("reset_exception", 32'(data_exception), 32'd0);
    check("reset_rdy", 32'(data_resultRDY), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // Reset held while ctrl_DIV is high: the start must be ignored.
    ctrl_DIV = 1'b1;
    data_operandA = 32'd100;
    data_operandB = 32'd7;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    check("reset_wins_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("reset_wins_idle", 32'(busy), 32'd0);

    run("pos_pos",   32'd100,       32'd7,          34, 32'd14,        32'd2,         1'b0);
    run("neg_pos",   32'hFFFFFF9C,  32'd7,          34, 32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0);
    run("pos_neg",   32'd100,       32'hFFFFFFF9,   34, 32'hFFFFFFF2,  32'd2,         1'b0);
    run("neg_neg",   32'hFFFFFFF9,  32'hFFFFFFFE,   34, 32'd3,         32'hFFFFFFFF,  1'b0);
    run("small_big", 32'd7,         32'd100,        34, 32'd0,         32'd7,         1'b0);
    run("m1_m1",     32'hFFFFFFFF,  32'hFFFFFFFF,   34, 32'd1,         32'd0,         1'b0);
    run("min_by_1",  32'h80000000,  32'd1,          34, 32'h80000000,  32'd0,         1'b0);
    run("min_by_2",  32'h80000000,  32'd2,          34, 32'hC0000000,  32'd0,         1'b0);
    run("div_zero",  32'd5,         32'd0,          1,  32'd0,         32'd5,         1'b1);
    run("div_zero_n",32'hFFFFFFFB,  32'd0,          1,  32'd0,         32'hFFFFFFFB,  1'b1);
    run("overflow",  32'h80000000,  32'hFFFFFFFF,   34, 32'h80000000,  32'd0,         1'b1);

    // Restart five edges into a divide; only the second one may complete.
    issue(32'd9, 32'd2);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clock);
      #1;
      check("restart_no_early_rdy", 32'(data_resultRDY), 32'd0);
    end
    issue(32'd50, 32'd5);
    expect_done("restart", 34, 32'd10, 32'd0, 1'b0);

    // Reset sampled at edge T+10 aborts the divide and clears the outputs.
    begin
      int pulses = 0;
      issue(32'd100, 32'd7);
      repeat (9) @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;
      check("midreset_result", data_result, 32'd0);
      check("midreset_remainder", data_remainder, 32'd0);
      check("midreset_exception", 32'(data_exception), 32'd0);
      check("midreset_rdy", 32'(data_resultRDY), 32'd0);
      check("midreset_busy", 32'(busy), 32'd0);
      for (int k = 0; k < 40; k++) begin
        @(posedge clock);
        #1;
        if (data_resultRDY) pulses++;
      end
      check("midreset_no_rdy", 32'(pulses), 32'd0);
      $display("midreset: rdy pulses after abort=%0d", pulses);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
